i2c_target_regbank: RTL

- I2C target (slave) register bank that sits directly downstream of the I2C master peripheral on the same SCL/SDA bus.
- Consumes the master's scl and the wired-AND SDA level, and returns ACKs and read data by pulling SDA low.
- Gives the on-chip master a loopback target for bring-up and regression, and lets the board observe writes on LEDs.
- Single clock domain; SCL and SDA are oversampled, never used as clocks.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_target_regbank_if.sv | 10 +
 rtl/i2c_bus_sync.sv | 86 ++++++++
 rtl/i2c_target_regbank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register bank.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_target_regbank_if.sv
// SCL/SDA bus bundle between the on-chip master side and the target.
// sda_in is the wired-AND bus level formed outside the target.
interface i2c_target_regbank_if;
  logic scl_in;
  logic sda_in;
  logic sda_pull_low;

  modport master (output scl_in, output sda_in, input sda_pull_low);
  modport slave  (input scl_in, input sda_in, output sda_pull_low);
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus START/STOP/SCL-edge detection.
// Optional macro I2C_GLITCH_FILTER_EN inserts a 3-sample persistence filter
// (2 cycles extra latency, pulses of <= 2 cycles rejected).
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   w_scl_s;
  logic                   w_sda_s;
  logic                   r_scl_prev;
  logic                   r_sda_prev;

  // Multi-flop synchronizers, idle-high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] w_raw;
  logic [1:0] r_h1;
  logic [1:0] r_h2;
  logic [1:0] r_hold;
  logic [1:0] w_agree;
  logic [1:0] w_filt;

  // Output follows the raw level combinationally once three samples agree,
  // so the filter costs exactly two cycles rather than three.
  assign w_raw   = {r_scl_sync[SYNC_STAGES-1], r_sda_sync[SYNC_STAGES-1]};
  assign w_agree = ~(w_raw ^ r_h1) & ~(r_h1 ^ r_h2);
  assign w_filt  = (w_agree & w_raw) | (~w_agree & r_hold);
  assign w_scl_s = w_filt[1];
  assign w_sda_s = w_filt[0];

  // Sample history and held filter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1   <= '1;
      r_h2   <= '1;
      r_hold <= '1;
    end else begin
      r_h1   <= w_raw;
      r_h2   <= r_h1;
      r_hold <= w_filt;
    end
  end
`else
  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];
`endif

  // Previous sampled levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl_s;
      r_sda_prev <= w_sda_s;
    end
  end

  assign sda_s     = w_sda_s;
  assign scl_rise  =  w_scl_s & ~r_scl_prev;
  assign scl_fall  = ~w_scl_s &  r_scl_prev;
  assign start_det =  w_scl_s &  r_sda_prev & ~w_sda_s;
  assign stop_det  =  w_scl_s & ~r_sda_prev &  w_sda_s;

endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target register bank: address match, pointer load, byte writes with
// auto-increment, sequential reads, local readback port.
// Optional macro I2C_GLITCH_FILTER_EN (in i2c_bus_sync) filters SCL/SDA.
module i2c_target_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned PTR_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  i2c_target_regbank_if.slave   bus,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [7:0]            wr_data,
  input  logic [PTR_W-1:0]      rd_sel,
  output logic [7:0]            rd_value
);

  localparam int unsigned DEPTH = 1 << PTR_W;

  logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start_det),
    .stop_det  (w_stop_det),
    .sda_s     (w_sda_s)
  );

  i2c_state_e       r_state, w_state;
  logic [3:0]       r_cnt, w_cnt;
  logic [7:0]       r_shift, w_shift;
  logic [PTR_W-1:0] r_ptr, w_ptr;
  logic             r_busy, w_busy;
  logic             r_pull, w_pull;
  logic             r_rw, w_rw;
  logic             r_phase, w_phase;
  logic             r_wr_strobe, w_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr, w_wr_addr;
  logic [7:0]       r_wr_data, w_wr_data;
  logic             w_we;
  logic [7:0]       w_byte;
  logic [7:0]       w_rd_byte;
  logic [7:0]       r_regs [DEPTH];

  assign w_byte    = {r_shift[6:0], w_sda_s};
  assign w_rd_byte = r_regs[r_ptr];

  // FSM and datapath state registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_pull      <= 1'b0;
      r_rw        <= I2C_RW_WRITE;
      r_phase     <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_shift     <= w_shift;
      r_ptr       <= w_ptr;
      r_busy      <= w_busy;
      r_pull      <= w_pull;
      r_rw        <= w_rw;
      r_phase     <= w_phase;
      r_wr_strobe <= w_wr_strobe;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
    end
  end

  // Register array; the local read port sees the old value during a write.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[r_ptr] <= w_byte;
    end
  end

  // Next-state and output logic; START/STOP override any bit activity.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_shift     = r_shift;
    w_ptr       = r_ptr;
    w_busy      = r_busy;
    w_pull      = r_pull;
    w_rw        = r_rw;
    w_phase     = r_phase;
    w_wr_strobe = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_we        = 1'b0;

    if (w_stop_det) begin
      w_state = ST_IDLE;
      w_busy  = 1'b0;
      w_pull  = 1'b0;
      w_cnt   = '0;
    end else if (w_start_det) begin
      w_state = ST_ADDR;
      w_busy  = 1'b0;
      w_pull  = 1'b0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift = w_byte;
            w_cnt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt   = '0;
              w_phase = 1'b0;
              if (r_state == ST_ADDR) begin
                if (w_byte[7:1] == TARGET_ADDR) begin
                  w_state = ST_ADDR_ACK;
                  w_busy  = 1'b1;
                  w_rw    = w_byte[0];
                end else begin
                  w_state = ST_WAIT_STOP;
                end
              end else if (r_state == ST_PTR) begin
                w_ptr   = w_byte[PTR_W-1:0];
                w_state = ST_PTR_ACK;
              end else begin
                w_we        = 1'b1;
                w_wr_strobe = 1'b1;
                w_wr_addr   = r_ptr;
                w_wr_data   = w_byte;
                w_ptr       = r_ptr + 1'b1;
                w_state     = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_pull  = 1'b1;
              w_phase = 1'b1;
            end else begin
              w_pull  = 1'b0;
              w_phase = 1'b0;
              w_cnt   = '0;
              if (r_state == ST_ADDR_ACK && r_rw == I2C_RW_READ) begin
                // Release the ACK and present the first read bit on the same fall.
                w_shift = w_rd_byte;
                w_pull  = ~w_rd_byte[7];
                w_ptr   = r_ptr + 1'b1;
                w_state = ST_RDATA;
              end else if (r_state == ST_ADDR_ACK) begin
                w_state = ST_PTR;
              end else begin
                w_state = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_cnt = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt != 4'd0) begin
            if (r_cnt == 4'd8) begin
              w_pull  = 1'b0;
              w_phase = 1'b0;
              w_cnt   = '0;
              w_state = ST_RACK;
            end else begin
              w_shift = r_shift << 1;
              w_pull  = ~w_shift[7];
            end
          end
        end
        ST_RACK: begin
          if (w_scl_rise && !r_phase) begin
            if (w_sda_s == I2C_ACK) begin
              w_phase = 1'b1;
            end else begin
              w_busy  = 1'b0;
              w_state = ST_WAIT_STOP;
            end
          end else if (w_scl_fall && r_phase) begin
            w_phase = 1'b0;
            w_shift = w_rd_byte;
            w_pull  = ~w_rd_byte[7];
            w_ptr   = r_ptr + 1'b1;
            w_cnt   = '0;
            w_state = ST_RDATA;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          w_pull = 1'b0;
        end
        default: begin
          w_state = ST_IDLE;
          w_pull  = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_pull_low = r_pull;
  assign busy             = r_busy;
  assign wr_strobe        = r_wr_strobe;
  assign wr_addr          = r_wr_addr;
  assign wr_data          = r_wr_data;
  assign rd_value         = r_regs[rd_sel];

endmodule
